fpstep: RTL

- Front-panel step and strobe controller.
- Conditions the raw panel controls STEP, MODE and LOAD, which are mechanical, asynchronous and bouncy.
- Produces the clean `mode` and `step` levels consumed by the strobe generator, plus a timed `strob_fp` pulse for loading panel data into a stopped CPU.
- Sits directly upstream of the strobe generator; uses its `got` output as the "cycle idle" qualifier.

---
 rtl/fpstep.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/fpstep.sv
// Front-panel step/strobe controller: debounces STEP, MODE, LOAD and issues one timed strob_fp per LOAD press.
// Latency: raw edge to mode/step = 2 + DEBOUNCE_TICKS cycles; strob_fp rises the cycle after stop&got is seen while pending.
// Backpressure: a LOAD request waits in F_PEND for got; it is dropped if the CPU leaves stop. Build option FPSTEP_AUTOREPEAT_EN.
module fpstep #(
  parameter int DEBOUNCE_TICKS = 50000,
  parameter int STROB_FP_TICKS = 4
`ifdef FPSTEP_AUTOREPEAT_EN
  , parameter int REPEAT_DELAY_TICKS = 25000000
  , parameter int REPEAT_RATE_TICKS  = 5000000
`endif
) (
  input  logic __clk,
  input  logic rst_,
  input  logic sw_step_,
  input  logic sw_mode,
  input  logic sw_load_,
  input  logic stop,
  input  logic got,
  output logic mode,
  output logic step,
  output logic strob_fp,
  output logic fp_busy
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

  // Bit order in the per-input vectors.
  localparam int I_STEP = 0;
  localparam int I_MODE = 1;
  localparam int I_LOAD = 2;

  // Raw-level value of each input when released / off (STEP and LOAD are active-low).
  localparam logic [2:0] RAW_IDLE = 3'b101;

  localparam logic [1:0] F_IDLE  = 2'd0;
  localparam logic [1:0] F_PEND  = 2'd1;
  localparam logic [1:0] F_PULSE = 2'd2;
  localparam logic [1:0] F_HOLD  = 2'd3;

  logic [2:0] sync1_q, sync2_q;
  logic [2:0] sig;   // synchronised, active-high
  logic [2:0] deb;   // debounced, active-high

  // Two-flop synchronisers for the asynchronous panel inputs.
  always_ff @(posedge __clk or negedge rst_) begin
    if (!rst_) begin
      sync1_q <= RAW_IDLE;
      sync2_q <= RAW_IDLE;
    end else begin
      sync1_q <= {sw_load_, sw_mode, sw_step_};
      sync2_q <= sync1_q;
    end
  end

  assign sig = sync2_q ^ RAW_IDLE;

  for (genvar g = 0; g < 3; g++) begin : g_db
    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_q, deb_d;

    // Count consecutive cycles of disagreement; flip only after an unbroken run.
    always_comb begin
      cnt_d = '0;
      deb_d = deb_q;
      if (sig[g] != deb_q) begin
        if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
          deb_d = ~deb_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Debounce state registers.
    always_ff @(posedge __clk or negedge rst_) begin
      if (!rst_) begin
        cnt_q <= '0;
        deb_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        deb_q <= deb_d;
      end
    end

    assign deb[g] = deb_q;
  end

  // LOAD edge qualification. After reset the debounced LOAD starts released, so a
  // button still held through reset would look like a fresh press once it debounces.
  // armed_q only sets once the synchroniser has refilled and LOAD is seen released.
  logic       load_prev_q;
  logic [1:0] fill_q, fill_d;
  logic       armed_q, armed_d;
  logic       load_edge;

  // Arming logic for the LOAD edge detector.
  always_comb begin
    fill_d  = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
    armed_d = armed_q | ((fill_q == 2'd2) & ~sig[I_LOAD] & ~deb[I_LOAD]);
  end

  // LOAD history and arming registers.
  always_ff @(posedge __clk or negedge rst_) begin
    if (!rst_) begin
      load_prev_q <= 1'b0;
      fill_q      <= 2'd0;
      armed_q     <= 1'b0;
    end else begin
      load_prev_q <= deb[I_LOAD];
      fill_q      <= fill_d;
      armed_q     <= armed_d;
    end
  end

  assign load_edge = armed_q & deb[I_LOAD] & ~load_prev_q;

  logic [1:0] state_q, state_d;
  logic [7:0] pcnt_q, pcnt_d;
  logic       strob_q, strob_d;

  // Strobe FSM: request, wait for idle stopped CPU, pulse, then wait for release.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    strob_d = 1'b0;
    case (state_q)
      F_IDLE: begin
        if (load_edge) state_d = F_PEND;
      end
      F_PEND: begin
        if (!stop) begin
          state_d = F_IDLE;
        end else if (got) begin
          state_d = F_PULSE;
          pcnt_d  = 8'(STROB_FP_TICKS - 1);
          strob_d = 1'b1;
        end
      end
      F_PULSE: begin
        // Runs to completion regardless of stop/got.
        if (pcnt_q == 8'd0) begin
          state_d = F_HOLD;
        end else begin
          pcnt_d  = pcnt_q - 8'd1;
          strob_d = 1'b1;
        end
      end
      F_HOLD: begin
        if (!deb[I_LOAD]) state_d = F_IDLE;
      end
      default: state_d = F_IDLE;
    endcase
  end

  // Strobe FSM registers.
  always_ff @(posedge __clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= F_IDLE;
      pcnt_q  <= 8'd0;
      strob_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      strob_q <= strob_d;
    end
  end

  assign strob_fp = strob_q;
  assign fp_busy  = (state_q != F_IDLE);
  assign mode     = deb[I_MODE];

`ifdef FPSTEP_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ? REPEAT_DELAY_TICKS
                                                                 : REPEAT_RATE_TICKS;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          rdly_done_q, rdly_done_d;
  logic          gap_q, gap_d;

  // Auto-repeat: after the initial delay, punch a one-cycle hole in step every period.
  always_comb begin
    rcnt_d      = '0;
    rdly_done_d = 1'b0;
    gap_d       = 1'b0;
    if (deb[I_STEP] && deb[I_MODE]) begin
      rdly_done_d = rdly_done_q;
      if (!rdly_done_q) begin
        if (rcnt_q == RW'(REPEAT_DELAY_TICKS - 1)) begin
          gap_d       = 1'b1;
          rdly_done_d = 1'b1;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end else begin
        if (rcnt_q == RW'(REPEAT_RATE_TICKS - 1)) begin
          gap_d = 1'b1;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
    end
  end

  // Auto-repeat registers.
  always_ff @(posedge __clk or negedge rst_) begin
    if (!rst_) begin
      rcnt_q      <= '0;
      rdly_done_q <= 1'b0;
      gap_q       <= 1'b0;
    end else begin
      rcnt_q      <= rcnt_d;
      rdly_done_q <= rdly_done_d;
      gap_q       <= gap_d;
    end
  end

  assign step = deb[I_STEP] & ~gap_q;
`else
  assign step = deb[I_STEP];
`endif

endmodule
